serial_addsub_fsm: RTL

- Bit-serial two-operand adder/subtractor; operands arrive LSB-first, one bit pair per accepted cycle.
- Generalises the fixed 3-bit serial difference/borrow state machine:
  - parameterised word width;
  - runtime add/subtract mode;
  - input stall via valid qualifier;
  - explicit word framing;
  - end-of-word carry/borrow and signed-overflow flags.
- Sits between a serial operand source and a serial result sink in the lab datapath.

---
 rtl/serial_addsub_fsm.sv | 87 ++++++++
 1 files changed

// File: rtl/serial_addsub_fsm.sv
// Bit-serial LSB-first adder/subtractor with word framing and end-of-word CB/OVF flags.
// One-cycle latency from accepting edge to D/D_VALID; IN_VALID=0 stalls the word, START aborts and restarts.
module serial_addsub_fsm #(
  parameter int WIDTH = 8
) (
  input  logic CLK,
  input  logic CLR,
  input  logic START,
  input  logic MODE,
  input  logic IN_VALID,
  input  logic X,
  input  logic Y,
  output logic BUSY,
  output logic D,
  output logic D_VALID,
  output logic DONE,
  output logic CB,
  output logic OVF
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             c;
  logic             mode;

  logic y_eff;
  logic d_bit;
  logic c_next;
  logic ovf_bit;

  // y_eff is the operand actually added, so overflow uses one rule for both modes
  always_comb begin
    y_eff   = Y ^ mode;
    d_bit   = X ^ Y ^ c;
    c_next  = mode ? ((~X & Y) | (c & ~(X ^ Y)))
                   : ((X & Y) | (c & (X ^ Y)));
    ovf_bit = (X == y_eff) && (d_bit != X);
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state   <= IDLE;
      cnt     <= '0;
      c       <= 1'b0;
      mode    <= 1'b0;
      BUSY    <= 1'b0;
      D       <= 1'b0;
      D_VALID <= 1'b0;
      DONE    <= 1'b0;
      CB      <= 1'b0;
      OVF     <= 1'b0;
    end else begin
      D_VALID <= 1'b0;
      DONE    <= 1'b0;
      // START wins in both states: arm (or re-arm) and drop any same-cycle bit
      if (START) begin
        state <= RUN;
        BUSY  <= 1'b1;
        cnt   <= '0;
        c     <= 1'b0;
        mode  <= MODE;
        CB    <= 1'b0;
        OVF   <= 1'b0;
      end else if (state == RUN && IN_VALID) begin
        D       <= d_bit;
        D_VALID <= 1'b1;
        c       <= c_next;
        if (cnt == LAST) begin
          state <= IDLE;
          BUSY  <= 1'b0;
          cnt   <= '0;
          DONE  <= 1'b1;
          CB    <= c_next;
          OVF   <= ovf_bit;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
